// File: rtl/sim_mon_pkg.sv
// Shared types and defaults for the simulation exit monitor.
package sim_mon_pkg;

  typedef enum logic [1:0] {
    StatusRun     = 2'd0,
    StatusPass    = 2'd1,
    StatusFail    = 2'd2,
    StatusTimeout = 2'd3
  } sim_status_e;

  localparam logic [31:0] DefConsoleAddr = 32'h1001_5000;
  localparam logic [63:0] DefPassVal     = 64'h0000_0004_4433_3222;
  localparam logic [63:0] DefFailVal     = 64'h0000_0023_8234_8720;

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sim_char_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head.
module sim_char_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0]   wr_q, wr_d, rd_q, rd_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] head_q, head_d;
  logic             push_ok, pop_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AddrW] != rd_q[AddrW]) && (wr_q[AddrW-1:0] == rd_q[AddrW-1:0]);
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;
  assign head    = head_q;

  always_comb begin
    wr_d = wr_q + (AddrW+1)'(push_ok);
    rd_d = rd_q + (AddrW+1)'(pop_ok);
    // The new head is the byte being written when the read pointer lands on the write slot.
    if (push_ok && (rd_d == wr_q)) begin
      head_d = push_data;
    end else begin
      head_d = mem_q[rd_d[AddrW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
      if (push_ok) begin
        mem_q[wr_q[AddrW-1:0]] <= push_data;
      end
    end
  end

endmodule

// File: rtl/sim_exit_monitor.sv
// Passive end-of-test monitor: PASS/FAIL/TIMEOUT decision, console byte capture
// from AXI writes, and cycle / retired-instruction counters.
module sim_exit_monitor
  import sim_mon_pkg::*;
#(
  parameter int unsigned NUM_RETIRE   = 1,
  parameter int unsigned NUM_WB       = 2,
  parameter int unsigned AXI_DW       = 128,
  parameter logic [31:0] CONSOLE_ADDR = DefConsoleAddr,
  parameter logic [63:0] PASS_VAL     = DefPassVal,
  parameter logic [63:0] FAIL_VAL     = DefFailVal,
  parameter int unsigned WDT_PERIOD   = 50000,
  parameter int unsigned CHAR_DEPTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [NUM_RETIRE-1:0] retire,
  input  logic [NUM_WB*64-1:0]  wb_data,
  input  logic                  awvalid,
  input  logic                  awready,
  input  logic [31:0]           awaddr,
  input  logic [3:0]            awlen,
  input  logic                  wvalid,
  input  logic                  wready,
  input  logic                  wlast,
  input  logic [AXI_DW-1:0]     wdata,
  input  logic [AXI_DW/8-1:0]   wstrb,
  output logic                  char_valid,
  output logic [7:0]            char_data,
  input  logic                  char_ready,
  output logic                  done,
  output sim_status_e           status,
  output logic [31:0]           cycle_cnt,
  output logic [63:0]           retire_cnt,
  output logic                  char_ovf,
  output logic                  ord_err
);

  localparam int unsigned Lanes = AXI_DW / 32;
  localparam int unsigned StrbW = AXI_DW / 8;

  sim_status_e          state_q, state_d;
  logic                 done_q, done_d;
  logic [NUM_WB*64-1:0] wb_q;
  logic                 running, pass_hit, fail_hit, win_end, starve;
  logic [3:0]           ret_pc;
  logic [31:0]          win_cnt_q, win_cnt_d, win_ret_q, win_ret_d, cycle_q, cycle_d;
  logic [63:0]          retire_q, retire_d;

  assign running = (state_q == StatusRun);
  assign ret_pc  = popcount(8'(retire));

  always_comb begin
    pass_hit = 1'b0;
    fail_hit = 1'b0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_q[64*i +: 64] == PASS_VAL) pass_hit = 1'b1;
      if (wb_q[64*i +: 64] == FAIL_VAL) fail_hit = 1'b1;
    end
  end

  // Window end is the WDT_PERIOD-th cycle; its own retires still count.
  assign win_end = (win_cnt_q == 32'(WDT_PERIOD - 1));
  assign starve  = win_end && ((win_ret_q + 32'(ret_pc)) == 32'd0);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= StatusRun;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == StatusRun) begin
      if (pass_hit)      state_d = StatusPass;
      else if (fail_hit) state_d = StatusFail;
      else if (starve)   state_d = StatusTimeout;
    end
    done_d = (state_q == StatusRun) && (state_d != StatusRun);
  end

  always_comb begin
    status = state_q;
    done   = done_q;
  end

  always_comb begin
    cycle_d   = cycle_q;
    retire_d  = retire_q;
    win_cnt_d = win_cnt_q;
    win_ret_d = win_ret_q;
    if (running) begin
      cycle_d  = cycle_q + 32'd1;
      retire_d = retire_q + 64'(ret_pc);
      if (win_end) begin
        win_cnt_d = '0;
        win_ret_d = '0;
      end else begin
        win_cnt_d = win_cnt_q + 32'd1;
        win_ret_d = win_ret_q + 32'(ret_pc);
      end
    end
  end

  // AXI write tracking and console extraction.
  logic             aw_fire, w_fire, aw_hit, eff_valid, eff_hit;
  logic             pend_valid_q, pend_valid_d, pend_hit_q, pend_hit_d;
  logic             ord_err_q, ord_err_d, ovf_q, ovf_d;
  logic             lane_ok;
  logic [7:0]       lane_byte;
  logic [StrbW-1:0] lane_mask;
  logic             push_q, push_d;
  logic [7:0]       byte_q;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [7:0]       fifo_head;
  logic             unused_wdata;

  assign aw_fire      = awvalid & awready;
  assign w_fire       = wvalid & wready;
  assign unused_wdata = ^wdata;

  always_comb begin
    aw_hit       = (awaddr == CONSOLE_ADDR) && (awlen == 4'd0);
    eff_valid    = aw_fire | pend_valid_q;
    eff_hit      = aw_fire ? aw_hit : pend_hit_q;
    pend_valid_d = pend_valid_q;
    pend_hit_d   = pend_hit_q;
    if (aw_fire) begin
      pend_valid_d = 1'b1;
      pend_hit_d   = aw_hit;
    end
    if (w_fire && eff_valid && wlast) pend_valid_d = 1'b0;
    ord_err_d = ord_err_q | (w_fire & ~eff_valid);
  end

  always_comb begin
    lane_ok   = 1'b0;
    lane_byte = '0;
    lane_mask = '0;
    for (int k = 0; k < Lanes; k++) begin
      lane_mask          = '0;
      lane_mask[4*k +: 4] = 4'hF;
      if (wstrb == lane_mask) begin
        lane_ok   = 1'b1;
        lane_byte = wdata[32*k +: 8];
      end
    end
    push_d = w_fire & eff_valid & eff_hit & lane_ok & running;
  end

  assign fifo_pop = ~fifo_empty & char_ready;
  assign ovf_d    = ovf_q | (push_q & fifo_full & ~fifo_pop);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wb_q         <= '0;
      cycle_q      <= '0;
      retire_q     <= '0;
      win_cnt_q    <= '0;
      win_ret_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_hit_q   <= 1'b0;
      ord_err_q    <= 1'b0;
      ovf_q        <= 1'b0;
      push_q       <= 1'b0;
      byte_q       <= '0;
    end else begin
      wb_q         <= wb_data;
      cycle_q      <= cycle_d;
      retire_q     <= retire_d;
      win_cnt_q    <= win_cnt_d;
      win_ret_q    <= win_ret_d;
      pend_valid_q <= pend_valid_d;
      pend_hit_q   <= pend_hit_d;
      ord_err_q    <= ord_err_d;
      ovf_q        <= ovf_d;
      push_q       <= push_d;
      byte_q       <= lane_byte;
    end
  end

  sim_char_fifo #(
    .Depth(CHAR_DEPTH),
    .Width(8)
  ) u_char_fifo (
    .clk      (clk),
    .rst_b    (rst_b),
    .push     (push_q),
    .push_data(byte_q),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign char_valid = ~fifo_empty;
  assign char_data  = fifo_head;
  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;
  assign char_ovf   = ovf_q;
  assign ord_err    = ord_err_q;

endmodule

// File: tb/tb_sim_exit_monitor.sv
// Scoreboard bench for sim_exit_monitor: console bytes are queued when driven and
// compared as the consumer accepts them; status/counter checks run inline.
module tb_sim_exit_monitor;

  localparam int unsigned NumRetire   = 1;
  localparam int unsigned NumWb       = 2;
  localparam int unsigned AxiDw       = 128;
  localparam int unsigned WdtPeriod   = 100;
  localparam int unsigned CharDepth   = 16;
  localparam logic [31:0] ConsoleAddr = 32'h1001_5000;
  localparam logic [63:0] PassVal     = 64'h4_4433_3222;
  localparam logic [63:0] FailVal     = 64'h23_8234_8720;

  logic                 clk, rst_b;
  logic [NumRetire-1:0] retire;
  logic [NumWb*64-1:0]  wb_data;
  logic                 awvalid, awready, wvalid, wready, wlast;
  logic [31:0]          awaddr;
  logic [3:0]           awlen;
  logic [AxiDw-1:0]     wdata;
  logic [AxiDw/8-1:0]   wstrb;
  logic                 char_valid, char_ready, done, char_ovf, ord_err;
  logic [7:0]           char_data;
  logic [1:0]           status;
  logic [31:0]          cycle_cnt;
  logic [63:0]          retire_cnt;

  sim_exit_monitor #(
    .NUM_RETIRE  (NumRetire),
    .NUM_WB      (NumWb),
    .AXI_DW      (AxiDw),
    .CONSOLE_ADDR(ConsoleAddr),
    .PASS_VAL    (PassVal),
    .FAIL_VAL    (FailVal),
    .WDT_PERIOD  (WdtPeriod),
    .CHAR_DEPTH  (CharDepth)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .retire    (retire),
    .wb_data   (wb_data),
    .awvalid   (awvalid),
    .awready   (awready),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .wvalid    (wvalid),
    .wready    (wready),
    .wlast     (wlast),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .char_valid(char_valid),
    .char_data (char_data),
    .char_ready(char_ready),
    .done      (done),
    .status    (status),
    .cycle_cnt (cycle_cnt),
    .retire_cnt(retire_cnt),
    .char_ovf  (char_ovf),
    .ord_err   (ord_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_bus();
    awvalid = 1'b0; awready = 1'b0; awaddr = '0; awlen = '0;
    wvalid  = 1'b0; wready  = 1'b0; wlast  = 1'b0;
    wdata   = '0;   wstrb   = '0;
  endtask

  // Holds reset for two edges, checks cleared state, releases at a negedge.
  task automatic reset_and_check();
    @(negedge clk);
    rst_b   = 1'b0;
    wb_data = '0;
    idle_bus();
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("rst_status", status, 0);
    check("rst_done", done, 0);
    check("rst_char_valid", char_valid, 0);
    check("rst_char_data", char_data, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_retire_cnt", retire_cnt, 0);
    check("rst_char_ovf", char_ovf, 0);
    check("rst_ord_err", ord_err, 0);
    rst_b = 1'b1;
  endtask

  task automatic aw_only(input logic [31:0] addr, input logic [3:0] len);
    awvalid = 1'b1; awready = 1'b1; awaddr = addr; awlen = len;
    tick();
    idle_bus();
  endtask

  task automatic console_beat(input logic [7:0] ch, input int lane, input logic [15:0] strb,
                              input bit with_aw, input bit expect_byte);
    logic [AxiDw-1:0] d;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    d[32*lane +: 8] = ch;
    if (with_aw) begin
      awvalid = 1'b1; awready = 1'b1; awaddr = ConsoleAddr; awlen = 4'd0;
    end
    wvalid = 1'b1; wready = 1'b1; wlast = 1'b1; wdata = d; wstrb = strb;
    if (expect_byte && (exp_q.size() < CharDepth)) exp_q.push_back(ch);
    tick();
    idle_bus();
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    check(tag, exp_q.size(), 0);
  endtask

  // Consumer side: compare each accepted byte against the head of the queue.
  always begin
    @(negedge clk);
    #2;
    if (rst_b && char_valid && char_ready) begin
      if (exp_q.size() == 0) begin
        check("char_spurious", char_valid, 0);
      end else begin
        check("char_data", char_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_b = 1'b0; retire = '0; wb_data = '0; char_ready = 1'b0;
    idle_bus();

    // Console capture and timing.
    retire = 1'b1;
    reset_and_check();
    console_beat(8'h41, 2, 16'h0F00, 1, 1);
    check("char_lat_edge_n", char_valid, 0);
    tick();
    check("char_lat_valid", char_valid, 1);
    check("char_lat_data", char_data, 8'h41);
    char_ready = 1'b1;
    wait_drain("drain_a");
    tick();
    check("char_empty_after", char_valid, 0);

    console_beat(8'h42, 2, 16'h0003, 1, 0);
    aw_only(ConsoleAddr, 4'd0);
    console_beat(8'h43, 0, 16'h000F, 0, 1);
    console_beat(8'h44, 3, 16'hF000, 1, 1);
    aw_only(ConsoleAddr + 32'd4, 4'd0);
    console_beat(8'h45, 1, 16'h00F0, 0, 0);
    aw_only(ConsoleAddr, 4'd1);
    console_beat(8'h46, 1, 16'h00F0, 0, 0);
    wait_drain("drain_b");
    repeat (3) tick();
    check("no_byte_bad_strb_addr_len", char_valid, 0);

    check("ord_err_before", ord_err, 0);
    console_beat(8'h47, 0, 16'h000F, 0, 0);
    check("ord_err_set", ord_err, 1);
    repeat (3) tick();
    check("ord_err_no_byte", char_valid, 0);

    // Overflow: 20 writes into a 16-deep FIFO with no consumer.
    char_ready = 1'b0;
    reset_and_check();
    for (int i = 0; i < 20; i++) begin
      console_beat(8'h61 + 8'(i), i % 4, 16'h000F << (4 * (i % 4)), 1, 1);
      if (i == 15) begin
        tick();
        check("ovf_at_full", char_ovf, 0);
      end
    end
    repeat (2) tick();
    check("ovf_set", char_ovf, 1);
    check("ovf_queued", exp_q.size(), CharDepth);
    char_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() > 8; i++) tick();
    char_ready = 1'b0;
    check("half_drained", char_valid, 1);

    // Mid-run reset from a terminal state with a partly filled FIFO.
    wb_data = {64'h0, PassVal};
    tick();
    wb_data = '0;
    tick();
    check("pre_rst_pass", status, 1);
    reset_and_check();

    // PASS on tap 1: done two edges later, counters freeze.
    wb_data = {PassVal, 64'h0};
    tick();
    wb_data = '0;
    check("pass_edge1_status", status, 0);
    check("pass_edge1_done", done, 0);
    tick();
    check("pass_status", status, 1);
    check("pass_done", done, 1);
    check("pass_cycle_cnt", cycle_cnt, 2);
    check("pass_retire_cnt", retire_cnt, 2);
    tick();
    check("pass_done_pulse", done, 0);
    char_ready = 1'b1;
    console_beat(8'h48, 0, 16'h000F, 1, 0);
    repeat (4) tick();
    check("pass_status_hold", status, 1);
    check("pass_cycle_frozen", cycle_cnt, 2);
    check("pass_retire_frozen", retire_cnt, 2);
    check("pass_console_suppressed", char_valid, 0);

    // PASS beats FAIL in the same cycle; FAIL alone.
    reset_and_check();
    wb_data = {FailVal, PassVal};
    tick();
    wb_data = '0;
    tick();
    check("pass_over_fail", status, 1);
    reset_and_check();
    wb_data = {64'h0, FailVal};
    tick();
    wb_data = '0;
    tick();
    check("fail_status", status, 2);
    check("fail_done", done, 1);

    // Watchdog with no retires.
    retire = '0;
    reset_and_check();
    repeat (WdtPeriod - 1) tick();
    check("wdt_before", status, 0);
    tick();
    check("wdt_timeout", status, 3);
    check("wdt_done", done, 1);
    check("wdt_cycle_cnt", cycle_cnt, WdtPeriod);

    // A retire in the window's last cycle restarts the window.
    reset_and_check();
    repeat (WdtPeriod - 1) tick();
    retire = 1'b1;
    tick();
    retire = '0;
    check("wdt_rescue_edge", status, 0);
    repeat (50) tick();
    check("wdt_rescue_150", status, 0);
    check("wdt_rescue_retire_cnt", retire_cnt, 1);
    repeat (WdtPeriod - 51) tick();
    check("wdt_second_before", status, 0);
    tick();
    check("wdt_second_timeout", status, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
